tow_playfield: RTL and testbench

//  Controller end of the tug-of-war command link. Consumes the 3-bit move command from the

---
 rtl/tow_pkg.sv | 41 ++++
 rtl/tow_playfield_if.sv | 25 ++
 rtl/tow_score_counter.sv | 30 +++
 rtl/tow_playfield.sv | 126 ++++++++++++
 tb/tb_tow_playfield.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/tow_pkg.sv
// Shared types for the tug-of-war command link (playfield and delegator).
package tow_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD    = 3'b100,
        CMD_P1      = 3'b001,
        CMD_P2      = 3'b111,
        CMD_P1_BACK = 3'b110,
        CMD_P2_BACK = 3'b000
    } tow_cmd_e;

    typedef enum logic {
        PLAY,
        WIN
    } tow_phase_e;

    // Net effect of a command on the light position.
    typedef enum logic [1:0] {
        MvHold,
        MvDec,
        MvInc,
        MvIllegal
    } tow_move_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // Pull-back codes move toward centre: P1_BACK decrements, P2_BACK increments.
    function automatic tow_move_e tow_decode(logic [2:0] c);
        tow_move_e mv;
        case (tow_cmd_e'(c))
            CMD_HOLD:                 mv = MvHold;
            CMD_P1, CMD_P1_BACK:      mv = MvDec;
            CMD_P2, CMD_P2_BACK:      mv = MvInc;
            default:                  mv = MvIllegal;
        endcase
        return mv;
    endfunction

endpackage

// File: rtl/tow_playfield_if.sv
// Command/feedback bundle between the player-input delegator and the playfield.
interface tow_playfield_if #(
    parameter int unsigned NUM_LEDS = 9
);
    logic [2:0]          cmd;
    logic                deviate1;
    logic                deviate2;
    logic [NUM_LEDS-1:0] leds;
    logic [1:0]          winner;
    logic [2:0]          score1;
    logic [2:0]          score2;
    logic                cmd_err;

    // Delegator side: issues commands, observes playfield state.
    modport master (
        output cmd,
        input  deviate1, deviate2, leds, winner, score1, score2, cmd_err
    );

    // Playfield side.
    modport slave (
        input  cmd,
        output deviate1, deviate2, leds, winner, score1, score2, cmd_err
    );
endinterface

// File: rtl/tow_score_counter.sv
// Saturating win tally with asynchronous active-low clear.
module tow_score_counter #(
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [Width-1:0] score_o
);
    logic [Width-1:0] score_q, score_d;

    // Increment on request unless already at all-ones.
    always_comb begin
        score_d = score_q;
        if (inc_i && (score_q != '1)) begin
            score_d = score_q + 1'b1;
        end
    end

    // Tally register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score_o = score_q;
endmodule

// File: rtl/tow_playfield.sv
// Playfield controller: owns the light position, detects wins, holds the win
// display for HOLD_CYCLES, and keeps per-player win tallies.
module tow_playfield
    import tow_pkg::*;
#(
    parameter int unsigned NUM_LEDS    = 9,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input logic            clk,
    input logic            reset,
    tow_playfield_if.slave bus_io
);
    localparam int unsigned PosW   = $clog2(NUM_LEDS);
    localparam int unsigned CntW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned Center = NUM_LEDS / 2;

    tow_phase_e      phase_q, phase_d;
    logic [PosW-1:0] pos_q, pos_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      winner_q, winner_d;
    logic            cmd_err_q, cmd_err_d;
    logic            inc1, inc2;
    tow_move_e       move;

    assign move = tow_decode(bus_io.cmd);

    // Next-state for phase, position, hold counter, winner and error pulse.
    always_comb begin
        phase_d   = phase_q;
        pos_d     = pos_q;
        cnt_d     = cnt_q;
        winner_d  = winner_q;
        cmd_err_d = 1'b0;
        inc1      = 1'b0;
        inc2      = 1'b0;
        unique case (phase_q)
            PLAY: begin
                case (move)
                    MvDec: begin
                        // Stepping off the player1 end wins; position is left as is.
                        if (pos_q == '0) begin
                            phase_d  = WIN;
                            winner_d = WIN_P1;
                            inc1     = 1'b1;
                        end else begin
                            pos_d = pos_q - 1'b1;
                        end
                    end
                    MvInc: begin
                        if (pos_q == PosW'(NUM_LEDS - 1)) begin
                            phase_d  = WIN;
                            winner_d = WIN_P2;
                            inc2     = 1'b1;
                        end else begin
                            pos_d = pos_q + 1'b1;
                        end
                    end
                    MvIllegal: cmd_err_d = 1'b1;
                    default: ;
                endcase
            end
            WIN: begin
                // Commands are ignored; leave after exactly HOLD_CYCLES cycles.
                if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
                    phase_d  = PLAY;
                    pos_d    = PosW'(Center);
                    winner_d = WIN_NONE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q   <= PLAY;
            pos_q     <= PosW'(Center);
            cnt_q     <= '0;
            winner_q  <= WIN_NONE;
            cmd_err_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            pos_q     <= pos_d;
            cnt_q     <= cnt_d;
            winner_q  <= winner_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    tow_score_counter #(
        .Width (3)
    ) u_score1 (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (inc1),
        .score_o (bus_io.score1)
    );

    tow_score_counter #(
        .Width (3)
    ) u_score2 (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (inc2),
        .score_o (bus_io.score2)
    );

    // Display and centre-adjacent feedback, blanked during WIN.
    always_comb begin
        bus_io.leds     = '0;
        bus_io.deviate1 = 1'b0;
        bus_io.deviate2 = 1'b0;
        if (phase_q == PLAY) begin
            bus_io.leds     = NUM_LEDS'(1) << pos_q;
            bus_io.deviate1 = (pos_q == PosW'(Center - 1));
            bus_io.deviate2 = (pos_q == PosW'(Center + 1));
        end
    end

    assign bus_io.winner  = winner_q;
    assign bus_io.cmd_err = cmd_err_q;
endmodule

// File: tb/tb_tow_playfield.sv
// Randomized self-checking bench for tow_playfield against a behavioural model.
module tb_tow_playfield;
    localparam int unsigned NUM_LEDS    = 9;
    localparam int unsigned HOLD_CYCLES = 16;
    localparam int          C           = NUM_LEDS / 2;

    logic clk;
    logic reset;

    tow_playfield_if #(.NUM_LEDS(NUM_LEDS)) bus ();

    tow_playfield #(
        .NUM_LEDS    (NUM_LEDS),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: position, remaining WIN cycles, tallies, winner, pending error.
    int m_pos;
    int m_win_left;
    int m_s1;
    int m_s2;
    int m_winner;
    bit m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos      = C;
        m_win_left = 0;
        m_s1       = 0;
        m_s2       = 0;
        m_winner   = 0;
        m_err      = 0;
    endtask

    task automatic model_step(input logic [2:0] c);
        int dir;
        m_err = 0;
        if (m_win_left > 0) begin
            m_win_left--;
            if (m_win_left == 0) begin
                m_pos    = C;
                m_winner = 0;
            end
        end else begin
            case (c)
                3'b001, 3'b110: dir = -1;
                3'b111, 3'b000: dir = 1;
                3'b100:         dir = 0;
                default: begin
                    dir   = 0;
                    m_err = 1;
                end
            endcase
            if (dir == -1) begin
                if (m_pos == 0) begin
                    m_win_left = HOLD_CYCLES;
                    m_winner   = 1;
                    m_s1       = (m_s1 < 7) ? m_s1 + 1 : 7;
                end else begin
                    m_pos--;
                end
            end else if (dir == 1) begin
                if (m_pos == NUM_LEDS - 1) begin
                    m_win_left = HOLD_CYCLES;
                    m_winner   = 2;
                    m_s2       = (m_s2 < 7) ? m_s2 + 1 : 7;
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [NUM_LEDS-1:0] e_leds;
        bit in_win;
        in_win = (m_win_left > 0);
        e_leds = '0;
        if (!in_win) e_leds[m_pos] = 1'b1;
        check_eq({tag, ".leds"}, 32'(bus.leds), 32'(e_leds));
        check_eq({tag, ".dev1"}, 32'(bus.deviate1), 32'(!in_win && m_pos == C - 1));
        check_eq({tag, ".dev2"}, 32'(bus.deviate2), 32'(!in_win && m_pos == C + 1));
        check_eq({tag, ".winner"}, 32'(bus.winner), 32'(m_winner));
        check_eq({tag, ".score1"}, 32'(bus.score1), 32'(m_s1));
        check_eq({tag, ".score2"}, 32'(bus.score2), 32'(m_s2));
        check_eq({tag, ".cmd_err"}, 32'(bus.cmd_err), 32'(m_err));
    endtask

    // Drive one command for one cycle, advance the model, check #1 after the edge.
    task automatic step(input logic [2:0] c, input string tag);
        @(negedge clk);
        bus.cmd = c;
        @(posedge clk);
        model_step(c);
        #1;
        check_all(tag);
    endtask

    task automatic steps(input logic [2:0] c, input int n, input string tag);
        for (int i = 0; i < n; i++) step(c, tag);
    endtask

    initial begin
        logic [2:0] c;
        int bias;
        int r;

        reset   = 1'b0;
        bus.cmd = 3'b100;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst");
        @(negedge clk);
        reset = 1'b1;

        // 1: idle holds at centre.
        steps(3'b100, 5, "t1");
        check_eq("t1.leds_const", 32'(bus.leds), 32'h010);

        // 2: one step right, then pull-back to centre.
        step(3'b001, "t2a");
        check_eq("t2.dev1_set", 32'(bus.deviate1), 32'd1);
        step(3'b000, "t2b");
        check_eq("t2.dev1_clr", 32'(bus.deviate1), 32'd0);

        // 3: reach end (no win), step off (win), then hold.
        steps(3'b001, 4, "t3a");
        step(3'b001, "t3win");
        check_eq("t3.winner", 32'(bus.winner), 32'd1);
        steps(3'b100, HOLD_CYCLES, "t3hold");
        check_eq("t3.recentre", 32'(bus.leds), 32'h010);

        // 4: player2 wins; commands during WIN are ignored.
        steps(3'b111, 5, "t4a");
        check_eq("t4.score2", 32'(bus.score2), 32'd1);
        for (int i = 0; i < HOLD_CYCLES; i++) step((i % 2) ? 3'b010 : 3'b001, "t4win");

        // 5: illegal command pulse, then saturate player1 tally.
        step(3'b011, "t5err");
        check_eq("t5.err_pulse", 32'(bus.cmd_err), 32'd1);
        step(3'b100, "t5clr");
        for (int w = 0; w < 8; w++) begin
            steps(3'b001, 5, "t5run");
            steps(3'b100, HOLD_CYCLES, "t5hold");
        end
        check_eq("t5.sat", 32'(bus.score1), 32'd7);

        // 6: asynchronous reset mid-WIN.
        steps(3'b111, 5, "t6a");
        steps(3'b100, 3, "t6b");
        #1 reset = 1'b0;
        #1;
        model_reset();
        check_all("t6rst");
        @(posedge clk);
        #2 reset = 1'b1;

        // Random play with per-segment bias so wins happen in both directions.
        for (int seg = 0; seg < 40; seg++) begin
            bias = $urandom_range(0, 1);
            for (int i = 0; i < 64; i++) begin
                r = $urandom_range(0, 9);
                if (r < 5) begin
                    if (bias == 0) c = ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b110;
                    else           c = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000;
                end else if (r < 7) begin
                    if (bias == 0) c = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000;
                    else           c = ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b110;
                end else if (r < 8) begin
                    c = 3'b100;
                end else begin
                    c = 3'($urandom_range(0, 7));
                end
                step(c, "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
